simon_btn_input: RTL and testbench

//  Input side of the Simon button/LED interface: conditions the raw player buttons before the game core sees them.

---
 rtl/simon_pkg.sv | 16 +
 rtl/simon_debounce.sv | 50 +++++
 rtl/simon_btn_input.sv | 132 +++++++++++++
 tb/tb_simon_btn_input.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared Simon types: button count, button index type and the press-event FSM states.
// The game core imports the same package so both sides agree on index width and encoding.
package simon_pkg;

  localparam int NUM_BTNS = 4;
  localparam int IDX_W    = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1;

  typedef logic [IDX_W-1:0] btn_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    HOLD  = 2'd2
  } press_state_t;

endpackage

// File: rtl/simon_debounce.sv
// One button: 2-FF synchroniser followed by a millisecond-count debouncer.
// The held level only follows the synchronised input after it has differed for DEBOUNCE_MS ticks.
module simon_debounce
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic btn_raw,
  output logic btn_held
);

  localparam int CNT_W = $clog2(DEBOUNCE_MS + 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_held;
  logic [CNT_W-1:0] r_ms_cnt;
  logic [CNT_W-1:0] w_ms_next;

  assign w_ms_next = r_ms_cnt + CNT_W'(1);

  // Any cycle where input matches the held level restarts the count, so short glitches never accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_held   <= 1'b0;
      r_ms_cnt <= {CNT_W{1'b0}};
    end else begin
      r_meta <= btn_raw;
      r_sync <= r_meta;
      if (r_sync == r_held) begin
        r_ms_cnt <= {CNT_W{1'b0}};
      end else if (ms_tick) begin
        if (w_ms_next == CNT_W'(DEBOUNCE_MS)) begin
          r_held   <= r_sync;
          r_ms_cnt <= {CNT_W{1'b0}};
        end else begin
          r_ms_cnt <= w_ms_next;
        end
      end
    end
  end

  assign btn_held = r_held;

endmodule

// File: rtl/simon_btn_input.sv
// Simon button input conditioning: shared ms prescaler, per-button debounce, rise detect
// and a press-event FSM that offers one button index per press on a valid/ready handshake.
module simon_btn_input
  import simon_pkg::*;
#(
  parameter  int NUM_BTNS    = simon_pkg::NUM_BTNS,
  parameter  int DEBOUNCE_MS = 10,
  parameter  int TPM_W       = 16,
  localparam int IDX_BITS    = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TPM_W-1:0]    ticks_per_milli,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_held,
  output logic                press_valid,
  output logic [IDX_BITS-1:0] press_idx,
  input  logic                press_ready
);

  logic                r_rst_meta;
  logic                r_rst_sync;
  logic                w_rst_n;
  logic [TPM_W-1:0]    r_presc_cnt;
  logic                w_ms_tick;
  logic [NUM_BTNS-1:0] w_held;
  logic [NUM_BTNS-1:0] r_held_d;
  logic [NUM_BTNS-1:0] w_rise;
  press_state_t        r_state;
  logic                r_valid;
  logic [IDX_BITS-1:0] r_idx;

  function automatic logic [IDX_BITS-1:0] lowest_idx(input logic [NUM_BTNS-1:0] vec);
    lowest_idx = {IDX_BITS{1'b0}};
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_idx = IDX_BITS'(i);
    end
  endfunction

  // Reset asserts asynchronously but releases two clocks later, aligned to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= r_rst_meta;
    end
  end

  assign w_rst_n = r_rst_sync;

  // A 0 or 1 tick period means every clock is a millisecond; >= keeps the counter in range when the period shrinks.
  always_comb begin
    if (ticks_per_milli <= TPM_W'(1)) begin
      w_ms_tick = 1'b1;
    end else begin
      w_ms_tick = (r_presc_cnt >= (ticks_per_milli - TPM_W'(1)));
    end
  end

  // Free-running millisecond prescaler.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_presc_cnt <= {TPM_W{1'b0}};
    end else if (w_ms_tick) begin
      r_presc_cnt <= {TPM_W{1'b0}};
    end else begin
      r_presc_cnt <= r_presc_cnt + TPM_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    simon_debounce #(
      .DEBOUNCE_MS(DEBOUNCE_MS)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (w_rst_n),
      .ms_tick (w_ms_tick),
      .btn_raw (btn_raw[g]),
      .btn_held(w_held[g])
    );
  end

  assign btn_held = w_held;
  assign w_rise   = w_held & ~r_held_d;

  // Previous debounced levels for rise detection.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_held_d <= {NUM_BTNS{1'b0}};
    end else begin
      r_held_d <= w_held;
    end
  end

  // Press FSM: only IDLE looks at rises, so rises during OFFER/HOLD are dropped rather than queued.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
      r_idx   <= {IDX_BITS{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_rise) begin
            r_idx   <= lowest_idx(w_rise);
            r_valid <= 1'b1;
            r_state <= OFFER;
          end
        end
        OFFER: begin
          if (press_ready) begin
            r_valid <= 1'b0;
            r_state <= (|w_held) ? HOLD : IDLE;
          end
        end
        HOLD: begin
          if (w_held == {NUM_BTNS{1'b0}}) r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign press_valid = r_valid;
  assign press_idx   = r_idx;

endmodule

// File: tb/tb_simon_btn_input.sv
// Directed bench for simon_btn_input with 1 ms = 4 clk and a 3 ms debounce.
module tb_simon_btn_input;
  import simon_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tpm = 16'd4;
  logic [3:0]  btn_raw = 4'b0000;
  logic [3:0]  btn_held;
  logic        press_valid;
  logic [1:0]  press_idx;
  logic        press_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  simon_btn_input #(
    .NUM_BTNS   (4),
    .DEBOUNCE_MS(3),
    .TPM_W      (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ticks_per_milli(tpm),
    .btn_raw        (btn_raw),
    .btn_held       (btn_held),
    .press_valid    (press_valid),
    .press_idx      (press_idx),
    .press_ready    (press_ready)
  );

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_held(input string tag, input logic [3:0] mask, input bit want_set,
                           input int budget, output int n);
    n = 0;
    while ((n < budget) && (want_set ? ((btn_held & mask) == 4'b0000) : (btn_held != 4'b0000))) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  task automatic accept(input string tag);
    press_ready = 1'b1;
    @(negedge clk);
    press_ready = 1'b0;
    chk(tag, int'(press_valid), 0);
  endtask

  task automatic release_all(input string tag);
    int n;
    btn_raw = 4'b0000;
    wait_held({tag, "_rel"}, 4'b1111, 1'b0, 40, n);
    cyc(2);
    chk({tag, "_idle"}, int'(dut.r_state), int'(IDLE));
  endtask

  task automatic press_and_check(input string tag, input logic [3:0] pat, input int exp_idx);
    int n;
    btn_raw = pat;
    wait_held({tag, "_held"}, pat, 1'b1, 25, n);
    @(negedge clk);
    chk({tag, "_valid"}, int'(press_valid), 1);
    chk({tag, "_idx"}, int'(press_idx), exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit ok;

    // Reset
    cyc(3);
    chk("rst_held_in", int'(btn_held), 0);
    chk("rst_valid_in", int'(press_valid), 0);
    rst_n = 1'b1;
    cyc(3);
    chk("rst_held", int'(btn_held), 0);
    chk("rst_valid", int'(press_valid), 0);
    chk("rst_idx", int'(press_idx), 0);
    chk("rst_state", int'(dut.r_state), int'(IDLE));

    // 1: async reset mid-run with a button held
    press_and_check("t1_pre", 4'b0010, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_held", int'(btn_held), 0);
    chk("t1_async_valid", int'(press_valid), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("t1_no_early", int'(press_valid), 0);
    press_and_check("t1_again", 4'b0010, 1);
    accept("t1_acc");
    release_all("t1");

    // 2: clean press, latency, stability under backpressure, HOLD
    btn_raw = 4'b0100;
    wait_held("t2_held", 4'b0100, 1'b1, 25, n);
    chk("t2_lat_min", int'(n >= 10), 1);
    chk("t2_lat_max", int'(n <= 20), 1);
    chk("t2_valid_lag", int'(press_valid), 0);
    @(negedge clk);
    chk("t2_valid", int'(press_valid), 1);
    chk("t2_idx", int'(press_idx), 2);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(press_valid && (press_idx == 2'd2))) ok = 1'b0;
    end
    chk("t2_stable", int'(ok), 1);
    accept("t2_acc");
    cyc(3);
    chk("t2_hold", int'(dut.r_state), int'(HOLD));
    chk("t2_hold_valid", int'(press_valid), 0);
    release_all("t2");

    // 3: short glitches on button 1
    ok = 1'b1;
    repeat (10) begin
      btn_raw = 4'b0010;
      repeat (3) begin
        @(negedge clk);
        if ((btn_held != 4'b0000) || press_valid) ok = 1'b0;
      end
      btn_raw = 4'b0000;
      repeat (3) begin
        @(negedge clk);
        if ((btn_held != 4'b0000) || press_valid) ok = 1'b0;
      end
    end
    repeat (10) begin
      @(negedge clk);
      if ((btn_held != 4'b0000) || press_valid) ok = 1'b0;
    end
    chk("t3_glitch", int'(ok), 1);

    // 4: simultaneous press, lowest index wins, no queued event
    press_and_check("t4", 4'b1010, 1);
    chk("t4_both", int'(btn_held), 10);
    accept("t4_acc");
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (press_valid) ok = 1'b0;
    end
    chk("t4_no_b3", int'(ok), 1);
    chk("t4_hold", int'(dut.r_state), int'(HOLD));
    release_all("t4");
    press_and_check("t4_re", 4'b1000, 3);
    accept("t4_re_acc");
    release_all("t4_re");

    // 5: release before acceptance
    press_and_check("t5", 4'b0001, 0);
    btn_raw = 4'b0000;
    wait_held("t5_rel", 4'b1111, 1'b0, 40, n);
    cyc(2);
    chk("t5_still_valid", int'(press_valid), 1);
    chk("t5_still_idx", int'(press_idx), 0);
    accept("t5_acc");
    chk("t5_idle", int'(dut.r_state), int'(IDLE));
    press_and_check("t5_again", 4'b0001, 0);
    accept("t5_again_acc");
    release_all("t5_again");

    // 6a: ticks_per_milli=0 gives a tick every clock
    tpm = 16'd0;
    cyc(2);
    btn_raw = 4'b0100;
    wait_held("t6_held", 4'b0100, 1'b1, 25, n);
    chk("t6_lat", n, 5);
    @(negedge clk);
    chk("t6_valid", int'(press_valid), 1);
    chk("t6_idx", int'(press_idx), 2);
    accept("t6_acc");
    release_all("t6");

    // 6b: shrinking the period mid-count wraps immediately
    tpm = 16'd100;
    cyc(20);
    chk("t6_presc20", int'(dut.r_presc_cnt), 20);
    tpm = 16'd4;
    #1;
    chk("t6_tick", int'(dut.w_ms_tick), 1);
    @(negedge clk);
    chk("t6_wrap", int'(dut.r_presc_cnt), 0);
    cyc(2);
    chk("t6_presc2", int'(dut.r_presc_cnt), 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
